// File: rtl/otter_defines.sv
// Shared definitions for the OTTER multiply/divide unit.
// Holds the RV32M funct3 codes, the unit's FSM state type and fixed result constants.
// Pure declarations: no logic, no timing.
package otter_defines;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // Quotient returned for any divide by zero.
  localparam logic [31:0] MULDIV_DIV0_Q = 32'hFFFF_FFFF;
  // Returned for divide requests when the divider is not built.
  localparam logic [31:0] MULDIV_BAD    = 32'hDEAD_DEAD;

endpackage

// File: rtl/otter_div_iter.sv
// One restoring-division step: shift the next dividend bit into the remainder, subtract if it fits.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module otter_div_iter (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] trial;
  logic [32:0] diff;

  // quo_i holds the not-yet-consumed dividend bits in its top end; quotient bits enter at the bottom
  always_comb begin
    trial = {rem_i, quo_i[31]};
    diff  = trial - {1'b0, div_i};
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = trial[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide unit; divide datapath only when OTTER_MULDIV_DIV_EN is defined.
// Latency: 33 cycles from accept to out_valid for normal ops, 1 for special cases.
// Backpressure: result held stable until out_ready; in_ready only while idle.
module otter_muldiv
  import otter_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  func,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  muldiv_state_t state_q;
  logic [4:0]    cnt_q;
  logic [63:0]   acc_q;       // product, or {remainder, dividend/quotient} when dividing
  logic [31:0]   opa_q;       // multiplicand magnitude, or divisor magnitude
  logic [31:0]   opb_q;       // multiplier magnitude, consumed MSB first
  logic [2:0]    func_q;
  logic          neg_q;       // negate product / quotient at FIX
  logic          in_ready_q;
  logic          out_valid_q;
  logic [31:0]   result_q;
`ifdef OTTER_MULDIV_DIV_EN
  logic          neg_rem_q;   // remainder takes the dividend's sign
`endif

  logic          sgn_a_en, sgn_b_en, sign_a, sign_b, special;
  logic [31:0]   mag_a, mag_b, special_res;

  // Request decode at accept: operand signedness, magnitudes and bypass cases
  always_comb begin
    sgn_a_en    = (func == MULDIV_MULH) || (func == MULDIV_MULHSU) ||
                  (func == MULDIV_DIV)  || (func == MULDIV_REM);
    sgn_b_en    = (func == MULDIV_MULH) || (func == MULDIV_DIV) || (func == MULDIV_REM);
    sign_a      = sgn_a_en & src_a[31];
    sign_b      = sgn_b_en & src_b[31];
    mag_a       = sign_a ? -src_a : src_a;
    mag_b       = sign_b ? -src_b : src_b;
    special     = 1'b0;
    special_res = '0;
`ifdef OTTER_MULDIV_DIV_EN
    if (func[2]) begin
      if (src_b == '0) begin
        special     = 1'b1;
        special_res = func[1] ? src_a : MULDIV_DIV0_Q;
      end else if (sgn_a_en && (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF)) begin
        special     = 1'b1;
        special_res = func[1] ? 32'h0000_0000 : 32'h8000_0000;
      end
    end
`else
    if (func[2]) begin
      special     = 1'b1;
      special_res = MULDIV_BAD;
    end
`endif
  end

  logic [63:0] mul_step;
  logic [63:0] calc_d;

  // MSB-first shift-add: double the partial product, add the multiplicand if the next multiplier bit is set
  assign mul_step = {acc_q[62:0], 1'b0} + (opb_q[31] ? {32'b0, opa_q} : 64'b0);

`ifdef OTTER_MULDIV_DIV_EN
  logic [31:0] div_rem, div_quo;

  otter_div_iter u_div_iter (
    .rem_i (acc_q[63:32]),
    .quo_i (acc_q[31:0]),
    .div_i (opa_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  assign calc_d = func_q[2] ? {div_rem, div_quo} : mul_step;
`else
  assign calc_d = mul_step;
`endif

  logic [63:0] prod;
  logic [31:0] fix_d;

  // Sign fix-up and result selection applied in the FIX state
  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    fix_d = (func_q == MULDIV_MUL) ? prod[31:0] : prod[63:32];
`ifdef OTTER_MULDIV_DIV_EN
    if (func_q[2]) begin
      if (func_q[1]) fix_d = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
      else           fix_d = neg_q     ? -acc_q[31:0]  : acc_q[31:0];
    end
`endif
  end

  // Control FSM with registered handshake outputs, counter and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      func_q      <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef OTTER_MULDIV_DIV_EN
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            func_q     <= func;
            neg_q      <= sign_a ^ sign_b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
`ifdef OTTER_MULDIV_DIV_EN
            neg_rem_q  <= sign_a;
`endif
            if (special) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
              if (func[2]) begin
                acc_q <= {32'b0, mag_a};
                opa_q <= mag_b;
              end else begin
                acc_q <= '0;
                opa_q <= mag_a;
                opb_q <= mag_b;
              end
            end
          end
        end
        CALC: begin
          acc_q <= calc_d;
          opb_q <= {opb_q[30:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          result_q    <= fix_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
